// File: rtl/rv32m_pkg.sv
// rv32m_pkg: RV32M width, op codes and divider state type shared by the M-extension responders
package rv32m_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] OP_DIV = 5'b10100;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM = 5'b10110;
  localparam logic [4:0] OP_REMU = 5'b10111;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/rv32m_iter_divider.sv
// rv32m_iter_divider: radix-2 restoring divider for DIV/DIVU/REM/REMU with op_valid/busy/done handshake
module rv32m_iter_divider
  import rv32m_pkg::*;
#(
  parameter int XLEN = rv32m_pkg::XLEN,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [4:0]      op_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  div_state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] op_r;
  logic s1, s2, dz;
  logic [XLEN-1:0] rem, quo, dvs;
  logic is_div, sgn_in, dz_in, ovf_in, accept;
  logic [XLEN-1:0] a_mag, b_mag, early_res, nxt_rem, nxt_quo, fin;
  logic [XLEN:0] trial;
  assign is_div = op_sel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign sgn_in = ~op_sel[0];
  assign a_mag = sgn_in && rs1[XLEN-1] ? -rs1 : rs1;
  assign b_mag = sgn_in && rs2[XLEN-1] ? -rs2 : rs2;
  assign dz_in = rs2 == '0;
  assign ovf_in = sgn_in && rs1 == MIN && rs2 == '1;
  assign accept = state == IDLE && op_valid && is_div;
  assign early_res = dz_in ? (op_sel[1] ? rs1 : '1) : (op_sel[1] ? '0 : MIN);
  assign trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
  assign nxt_rem = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
  assign nxt_quo = {quo[XLEN-2:0], ~trial[XLEN]};
  // Divide-by-zero DIV needs an override: the iteration alone would negate the all-ones quotient
  assign fin = op_r[1] ? (~op_r[0] && s1 ? -nxt_rem : nxt_rem)
             : dz ? '1 : (~op_r[0] && (s1 ^ s2) ? -nxt_quo : nxt_quo);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r <= op_sel[1:0];
          s1 <= rs1[XLEN-1];
          s2 <= rs2[XLEN-1];
          dz <= dz_in;
          rem <= '0;
          quo <= a_mag;
          dvs <= b_mag;
          cnt <= CW'(XLEN-1);
          if (EARLY_OUT && (dz_in || ovf_in)) begin
            state <= DONE;
            done <= 1'b1;
            result <= early_res;
          end else begin
            state <= CALC;
            busy <= 1'b1;
          end
        end
        CALC: begin
          rem <= nxt_rem;
          quo <= nxt_quo;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            result <= fin;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
